bus_slave: RTL and testbench

BUS_SLAVE -- requirements
Module: bus_slave

---
 rtl/bus_slave.sv | 137 +++++++++++++
 tb/tb_bus_slave.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bus_slave.sv
// bus_slave: granted bus receiver feeding a show-ahead FIFO.
// Ports: clk, reset_n (sync, active-low), req/data_in/ack (bus side),
//   rd_en/rd_data/rd_valid/full/count (consumer side).
// Optional BUS_SLAVE_STATS_EN adds xfer_cnt[7:0], a saturating capture count.
module bus_slave #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req,
    input  logic [DATA_W-1:0]      data_in,
    output logic                   ack,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
`ifdef BUS_SLAVE_STATS_EN
    ,
    output logic [7:0]             xfer_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_S = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              ack_q, ack_d;
    logic              pipe_q, pipe_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [CW:0]       occ;
    logic              space;
    logic              cap;
    logic              pop;

    always_comb begin
        // Beats in flight: one granted by the current ack, one awaiting
        // capture. A same-cycle pop is deliberately not credited.
        occ   = {1'b0, count_q} + (CW+1)'(ack_q) + (CW+1)'(pipe_q);
        space = occ < DEPTH_S;
        cap   = pipe_q;
        pop   = rd_en && (count_q != '0);

        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req) state_d = space ? GRANT : HOLD;
            end
            GRANT: begin
                if (!req)       state_d = IDLE;
                else if (space) state_d = GRANT;
                else            state_d = HOLD;
            end
            HOLD: begin
                if (space)     state_d = GRANT;
                else if (!req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ack_d  = (state_d == GRANT);
        pipe_d = ack_q;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (cap) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

        count_d = count_q;
        unique case ({cap, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            pipe_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            assert (!(cap && count_q == DEPTH_C));
            state_q  <= state_d;
            ack_q    <= ack_d;
            pipe_q   <= pipe_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign ack      = ack_q;
    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = (count_q != '0);
    assign full     = (count_q == DEPTH_C);
    assign count    = count_q;

`ifdef BUS_SLAVE_STATS_EN
    logic [7:0] xfer_cnt_q, xfer_cnt_d;

    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (cap && xfer_cnt_q != 8'hff) xfer_cnt_d = xfer_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) xfer_cnt_q <= 8'd0;
        else          xfer_cnt_q <= xfer_cnt_d;
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_bus_slave.sv
// tb_bus_slave: table of per-cycle vectors for bus_slave plus a
// master model whose captured beats feed a data scoreboard.
module tb_bus_slave;

    localparam int DATA_W = 2;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req;
    logic [DATA_W-1:0] data_in;
    logic              ack;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic [2:0]        count;
`ifdef BUS_SLAVE_STATS_EN
    logic [7:0]        xfer_cnt;
`endif

    always #5 clk = ~clk;

    bus_slave #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .data_in  (data_in),
        .ack      (ack),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full),
`ifdef BUS_SLAVE_STATS_EN
        .xfer_cnt (xfer_cnt),
`endif
        .count    (count)
    );

    typedef struct {
        logic rn;
        logic r;
        logic rd;
        logic ack;
        int   cnt;
        logic full;
        logic chk0;
    } vec_t;

    vec_t              tbl[$];
    logic [DATA_W-1:0] sb_q[$];
    int                n_checks = 0;
    int                n_fail   = 0;
    logic              prev_ack = 1'b0;
    logic              last_rst = 1'b0;
    logic [DATA_W-1:0] beat     = 2'd1;
    int                caps     = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic rn, input logic r, input logic rd,
                       input logic a, input int c, input logic f,
                       input logic z);
        vec_t v;
        v.rn = rn; v.r = r; v.rd = rd; v.ack = a;
        v.cnt = c; v.full = f; v.chk0 = z;
        tbl.push_back(v);
    endtask

    // Master behaviour: a beat granted by ack (visible in one cycle) has
    // its data presented in the following cycle; other cycles carry junk.
    task automatic step(input logic r, input logic rd, input logic rn);
        logic cap;
        logic do_pop;
        cap    = prev_ack && last_rst && rn;
        do_pop = rd && rn && (sb_q.size() > 0);
        reset_n = rn;
        req     = r;
        rd_en   = rd;
        if (cap) begin
            data_in = beat;
            sb_q.push_back(beat);
            beat = beat + 2'd1;
            caps++;
        end else begin
            data_in = DATA_W'($urandom);
        end
        if (do_pop) void'(sb_q.pop_front());
        if (!rn) begin
            sb_q.delete();
            caps = 0;
        end
        prev_ack = ack;
        last_rst = rn;
        @(negedge clk);
        check("sb_count", int'(count), sb_q.size());
        check("sb_valid", int'(rd_valid), int'(sb_q.size() > 0));
        check("sb_full", int'(full), int'(sb_q.size() == DEPTH));
        if (sb_q.size() > 0) check("sb_head", int'(rd_data), int'(sb_q[0]));
`ifdef BUS_SLAVE_STATS_EN
        check("sb_xfer", int'(xfer_cnt), (caps > 255) ? 255 : caps);
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        @(negedge clk);

        // rn r rd | ack cnt full chk0
        add(0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 1);
        add(1, 1, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 1, 0, 0);
        add(1, 1, 0, 1, 2, 0, 0);
        add(1, 1, 0, 0, 3, 0, 0);
        add(1, 1, 0, 0, 4, 1, 0);
        add(1, 1, 0, 0, 4, 1, 0);
        add(1, 1, 1, 0, 3, 0, 0);
        add(1, 1, 0, 1, 3, 0, 0);
        add(1, 1, 0, 0, 3, 0, 0);
        add(1, 1, 0, 0, 4, 1, 0);
        add(1, 1, 0, 0, 4, 1, 0);
        add(1, 0, 1, 0, 3, 0, 0);
        add(1, 0, 1, 0, 2, 0, 0);
        add(1, 0, 1, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0);
        add(1, 1, 1, 1, 0, 0, 0);
        add(1, 1, 1, 1, 0, 0, 0);
        add(1, 1, 1, 1, 1, 0, 0);
        add(1, 1, 0, 1, 2, 0, 0);
        add(1, 1, 1, 0, 2, 0, 0);
        add(1, 1, 1, 1, 2, 0, 0);
        add(1, 0, 0, 0, 2, 0, 0);
        add(1, 0, 0, 0, 3, 0, 0);
        add(1, 0, 0, 0, 3, 0, 0);
        add(1, 1, 0, 1, 3, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].rd, tbl[i].rn);
            check($sformatf("ack[%0d]", i), int'(ack), int'(tbl[i].ack));
            check($sformatf("count[%0d]", i), int'(count), tbl[i].cnt);
            check($sformatf("full[%0d]", i), int'(full), int'(tbl[i].full));
            check($sformatf("valid[%0d]", i), int'(rd_valid),
                  int'(tbl[i].cnt != 0));
            if (tbl[i].chk0)
                check($sformatf("rd_data0[%0d]", i), int'(rd_data), 0);
        end

`ifdef BUS_SLAVE_STATS_EN
        for (int n = 0; n < 2000 && caps < 300; n++) step(1'b1, 1'b1, 1'b1);
        check("stats_caps_reached", int'(caps >= 300), 1);
        check("xfer_sat", int'(xfer_cnt), 255);
        step(1'b0, 1'b0, 1'b0);
        check("xfer_reset", int'(xfer_cnt), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
